// File: rtl/riscv_pkg.sv
// Shared core definitions: default datapath widths and the MEM-stage FSM state encoding.
package riscv_pkg;

  localparam int DEF_BIT_W  = 32;
  localparam int DEF_ADDR_W = 30;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: writeback data, rd and regwr, held while en is low.
module mem_wb_reg #(
  parameter int BIT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [BIT_W-1:0] dat_in,
  input  logic [4:0]       rd_in,
  input  logic             regwr_in,
  output logic [BIT_W-1:0] wb_dat,
  output logic [4:0]       wb_rd,
  output logic             wb_regwr
);

  // MEM -> WB boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_dat   <= '0;
      wb_rd    <= '0;
      wb_regwr <= 1'b0;
    end else if (en) begin
      wb_dat   <= dat_in;
      wb_rd    <= rd_in;
      wb_regwr <= regwr_in;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: D-cache load/store handshake, pipeline hold, MEM/WB register.
// Optional EX-stage forwarding source enabled by defining MEM_STAGE_FWD_EN.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int BIT_W  = DEF_BIT_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIT_W-1:0]  alu_result_in,
  input  logic [BIT_W-1:0]  mem_wdata_in,
  input  logic [4:0]        rd_in,
  input  logic [BIT_W-1:0]  PC_step_in,
  input  logic              memrd_in,
  input  logic              memwr_in,
  input  logic              mem2reg_in,
  input  logic              regwr_in,
  input  logic              jump_in,
  input  logic              stall_in,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BIT_W-1:0]  mem_wdata,
  input  logic [BIT_W-1:0]  mem_rdata,
  input  logic              mem_stall,
  output logic              stall_out,
  output logic [BIT_W-1:0]  wb_dat,
  output logic [4:0]        wb_rd,
  output logic              wb_regwr,
  output logic              fwd_valid,
  output logic [4:0]        fwd_rd,
  output logic [BIT_W-1:0]  fwd_dat
);

  mem_state_e       state;
  logic [BIT_W-1:0] ld_buf;
  logic             acc;
  logic             req;
  logic [BIT_W-1:0] ld_dat;
  logic [BIT_W-1:0] wb_sel;
  logic             wb_en;

  // DONE never re-issues, so a completed store cannot be written twice while the pipe is held.
  assign acc       = memrd_in | memwr_in;
  assign req       = rst_n & acc & ((state == MEM_IDLE) | (state == MEM_BUSY));
  assign mem_wen   = req & memwr_in;
  assign mem_ren   = req & memrd_in & ~memwr_in;
  assign mem_addr  = alu_result_in[ADDR_W+1:2];
  assign mem_wdata = mem_wdata_in;
  assign stall_out = req & mem_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= MEM_IDLE;
      ld_buf <= '0;
    end else begin
      case (state)
        MEM_IDLE, MEM_BUSY: begin
          if (acc) begin
            if (mem_stall) begin
              state <= MEM_BUSY;
            end else begin
              if (!memwr_in) ld_buf <= mem_rdata;
              state <= stall_in ? MEM_DONE : MEM_IDLE;
            end
          end else begin
            state <= MEM_IDLE;
          end
        end
        MEM_DONE: if (!stall_in) state <= MEM_IDLE;
        default:  state <= MEM_IDLE;
      endcase
    end
  end

  // Load data comes straight from the cache on completion, or from the buffer once held in DONE.
  assign ld_dat = (state == MEM_DONE) ? ld_buf : mem_rdata;
  assign wb_sel = mem2reg_in ? ld_dat : (jump_in ? PC_step_in : alu_result_in);
  assign wb_en  = ~(stall_out | stall_in);

  mem_wb_reg #(.BIT_W(BIT_W)) u_mem_wb_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (wb_en),
    .dat_in   (wb_sel),
    .rd_in    (rd_in),
    .regwr_in (regwr_in),
    .wb_dat   (wb_dat),
    .wb_rd    (wb_rd),
    .wb_regwr (wb_regwr)
  );

`ifdef MEM_STAGE_FWD_EN
  assign fwd_valid = regwr_in & (rd_in != 5'd0) & ~memrd_in;
  assign fwd_rd    = rd_in;
  assign fwd_dat   = jump_in ? PC_step_in : alu_result_in;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = '0;
  assign fwd_dat   = '0;
`endif

endmodule
